pll_reconfig_seq: RTL and testbench

Sequencer that programs the PLL reconfiguration controller over its Avalon-MM management slave (6-bit word address, 32-bit data, waitrequest). A single request supplies new N, M and one C counter value. The block writes them, triggers reconfiguration, polls for completion, then waits for the PLL to re-lock. It sits between the UART command logic and the pll_reconfig management port and owns that port exclusively.

---
 rtl/pll_reconfig_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// Purpose: programs N/M/C counters of a PLL reconfig controller over Avalon-MM, starts reconfig, polls status, waits for lock.
// Latency: done pulses 8 cycles after accept with zero waitrequest, immediate status done and lock already synchronized.
// Backpressure: each transfer holds address/data/strobe while mgmt_waitrequest=1; cfg_req is ignored (not queued) while busy.
module pll_reconfig_seq #(
    parameter int POLL_LIMIT   = 1024,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        cfg_req,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c,
    input  logic [4:0]  cfg_c_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_read,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest
);

    localparam int PW = $clog2(POLL_LIMIT) + 1;
    localparam int LW = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TIMEOUT);

    // Management register map of the reconfig controller
    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_N      = 6'h03;
    localparam logic [5:0] ADDR_M      = 6'h04;
    localparam logic [5:0] ADDR_C      = 6'h05;

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_POLL = 2'd1;
    localparam logic [1:0] CODE_LOCK = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C,
        S_WR_START,
        S_RD_STATUS,
        S_WAIT_LOCK,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        state_d;

    logic [17:0]   n_q;
    logic [17:0]   m_q;
    logic [17:0]   c_q;
    logic [4:0]    sel_q;
    logic [PW-1:0] poll_cnt;
    logic [LW-1:0] lock_cnt;
    logic [PW-1:0] poll_inc;
    logic [LW-1:0] lock_inc;
    logic [1:0]    err_code_q;
    logic          lock_meta;
    logic          lock_sync;
    logic          accept;
    logic          xfer_ok;
    logic          status_done;
    logic          unused_readdata;

    // Only the status done bit is consumed from the read data
    assign unused_readdata = ^mgmt_readdata[31:1];

    assign accept      = (state == S_IDLE) && cfg_req;
    assign xfer_ok     = (mgmt_read || mgmt_write) && !mgmt_waitrequest;
    assign status_done = mgmt_readdata[0];
    assign poll_inc    = poll_cnt + PW'(1);
    assign lock_inc    = lock_cnt + LW'(1);
    assign err_code    = err_code_q;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    // State register; reset abandons any in-flight transfer
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and Avalon/status outputs decoded from the current state
    always_comb begin
        state_d        = state;
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        mgmt_read      = 1'b0;
        mgmt_write     = 1'b0;
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'h0;
        case (state)
            S_IDLE: begin
                if (cfg_req) begin
                    state_d = S_WR_MODE;
                end
            end
            S_WR_MODE: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_MODE;
                mgmt_writedata = 32'd1;
                if (!mgmt_waitrequest) begin
                    state_d = S_WR_N;
                end
            end
            S_WR_N: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_N;
                mgmt_writedata = {14'b0, n_q};
                if (!mgmt_waitrequest) begin
                    state_d = S_WR_M;
                end
            end
            S_WR_M: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_M;
                mgmt_writedata = {14'b0, m_q};
                if (!mgmt_waitrequest) begin
                    state_d = S_WR_C;
                end
            end
            S_WR_C: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_C;
                mgmt_writedata = {9'b0, sel_q, c_q};
                if (!mgmt_waitrequest) begin
                    state_d = S_WR_START;
                end
            end
            S_WR_START: begin
                busy           = 1'b1;
                mgmt_write     = 1'b1;
                mgmt_address   = ADDR_START;
                mgmt_writedata = 32'h0;
                if (!mgmt_waitrequest) begin
                    state_d = S_RD_STATUS;
                end
            end
            S_RD_STATUS: begin
                busy         = 1'b1;
                mgmt_read    = 1'b1;
                mgmt_address = ADDR_STATUS;
                if (!mgmt_waitrequest) begin
                    if (status_done) begin
                        state_d = S_WAIT_LOCK;
                    end else if (poll_inc == POLL_MAX) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT_LOCK: begin
                busy = 1'b1;
                // Lock is checked first so it wins in the timeout cycle
                if (lock_sync) begin
                    state_d = S_DONE;
                end else if (lock_inc == LOCK_MAX) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture the request so later cfg_* changes cannot disturb the sequence
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            n_q   <= 18'h0;
            m_q   <= 18'h0;
            c_q   <= 18'h0;
            sel_q <= 5'h0;
        end else if (accept) begin
            n_q   <= cfg_n;
            m_q   <= cfg_m;
            c_q   <= cfg_c;
            sel_q <= cfg_c_sel;
        end
    end

    // Status poll counter: one step per completed read that reports not-done
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            poll_cnt <= '0;
        end else if (accept) begin
            poll_cnt <= '0;
        end else if (state == S_RD_STATUS && xfer_ok && !status_done) begin
            poll_cnt <= poll_inc;
        end
    end

    // Lock wait counter: one step per WAIT_LOCK cycle; the state exits before it could wrap
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lock_cnt <= '0;
        end else if (accept) begin
            lock_cnt <= '0;
        end else if (state == S_WAIT_LOCK) begin
            lock_cnt <= lock_inc;
        end
    end

    // Error code is set on the way into ERR and held until the next accept
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            err_code_q <= CODE_NONE;
        end else if (accept) begin
            err_code_q <= CODE_NONE;
        end else if (state_d == S_ERR && state == S_RD_STATUS) begin
            err_code_q <= CODE_POLL;
        end else if (state_d == S_ERR && state == S_WAIT_LOCK) begin
            err_code_q <= CODE_LOCK;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Purpose: randomized self-checking bench for pll_reconfig_seq against a transaction-level model.
// Latency: expected done/err cycle derived from the chosen stall counts and status/lock behaviour.
// Backpressure: a slave model inserts waitrequest stalls and checks the master holds the transfer.
module tb_pll_reconfig_seq;

    localparam int POLL_LIMIT   = 4;
    localparam int LOCK_TIMEOUT = 16;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        cfg_req;
    logic [17:0] cfg_n, cfg_m, cfg_c;
    logic [4:0]  cfg_c_sel;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_read, mgmt_write;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    pll_reconfig_seq #(
        .POLL_LIMIT  (POLL_LIMIT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .cfg_req         (cfg_req),
        .cfg_n           (cfg_n),
        .cfg_m           (cfg_m),
        .cfg_c           (cfg_c),
        .cfg_c_sel       (cfg_c_sel),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .err_code        (err_code),
        .pll_locked      (pll_locked),
        .mgmt_address    (mgmt_address),
        .mgmt_read       (mgmt_read),
        .mgmt_write      (mgmt_write),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_readdata   (mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model state; a transaction entry is {is_read, address, write data}
    bit          in_xfer = 1'b0;
    logic [38:0] rec, cur;
    int          rem          = 0;
    int          stall_fixed  = 0;   // -1 selects a random 0..3 stall per transfer
    int          status_zeros = 0;   // not-done status replies before the first done
    int          status_reads = 0;
    int          xfer_cycles  = 0;
    int          done_cnt     = 0;
    int          err_cnt      = 0;
    int          end_cyc      = 0;
    logic        end_busy;
    logic [1:0]  end_code;
    logic [38:0] xlog[$];
    logic [38:0] exp_q[$];
    logic [31:0] rd;

    // Avalon slave and bus monitor, evaluated mid-cycle
    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            in_xfer          = 1'b0;
            mgmt_waitrequest = 1'b0;
        end else begin
            chk("rw_excl", 64'(mgmt_read & mgmt_write), 64'd0);
            chk("idle_quiet", 64'((mgmt_read | mgmt_write) & ~busy), 64'd0);
            if (done || err) begin
                end_cyc  = cyc;
                end_busy = busy;
                end_code = err_code;
                if (done) done_cnt++;
                if (err)  err_cnt++;
            end
            if (mgmt_read || mgmt_write) begin
                cur = {mgmt_read, mgmt_address, mgmt_write ? mgmt_writedata : 32'h0};
                if (!in_xfer) begin
                    in_xfer = 1'b1;
                    rec     = cur;
                    rem     = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
                    xfer_cycles += rem + 1;
                end else begin
                    chk("stall_stable", 64'(cur), 64'(rec));
                end
                if (rem > 0) begin
                    mgmt_waitrequest = 1'b1;
                    mgmt_readdata    = $urandom;
                    rem--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    in_xfer          = 1'b0;
                    xlog.push_back(rec);
                    if (mgmt_read) begin
                        rd            = $urandom;
                        rd[0]         = (status_reads >= status_zeros);
                        status_reads++;
                        mgmt_readdata = rd;
                    end
                end
            end else begin
                if (in_xfer) chk("strobe_held", 64'd0, 64'd1);
                in_xfer          = 1'b0;
                mgmt_waitrequest = 1'($urandom_range(0, 1));
                mgmt_readdata    = $urandom;
            end
        end
    end

    task automatic build_exp(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c,
                             input logic [4:0] sel, input int nreads);
        exp_q.delete();
        exp_q.push_back({1'b0, 6'h00, 32'd1});
        exp_q.push_back({1'b0, 6'h03, {14'b0, n}});
        exp_q.push_back({1'b0, 6'h04, {14'b0, m}});
        exp_q.push_back({1'b0, 6'h05, {9'b0, sel, c}});
        exp_q.push_back({1'b0, 6'h02, 32'd0});
        for (int i = 0; i < nreads; i++) exp_q.push_back({1'b1, 6'h01, 32'd0});
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 64'(xlog.size()), 64'(exp_q.size()));
        for (int i = 0; i < xlog.size() && i < exp_q.size(); i++)
            chk({tag, "_xfer"}, 64'(xlog[i]), 64'(exp_q[i]));
    endtask

    task automatic do_req(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c,
                          input logic [4:0] sel, output int acc);
        @(posedge clk_clk); #1;
        xlog.delete();
        status_reads = 0;
        xfer_cycles  = 0;
        cfg_n = n; cfg_m = m; cfg_c = c; cfg_c_sel = sel;
        cfg_req = 1'b1;
        acc = cyc;
        @(posedge clk_clk); #1;
        cfg_req = 1'b0;
        cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_c = 18'($urandom); cfg_c_sel = 5'($urandom);
        chk("busy_set", 64'(busy), 64'd1);
        chk("code_clr", 64'(err_code), 64'd0);
    endtask

    // kind: 1 = done, 2 = err, 0 = no end seen within the budget
    task automatic wait_end(output int kind);
        int g  = 0;
        int d0 = done_cnt;
        int e0 = err_cnt;
        while (done_cnt == d0 && err_cnt == e0 && g < 3000) begin
            @(negedge clk_clk);
            g++;
        end
        if (done_cnt != d0)     kind = 1;
        else if (err_cnt != e0) kind = 2;
        else begin
            kind = 0;
            chk("end_timeout", 64'd1, 64'd0);
        end
    endtask

    // extra: cycles after the last transfer until the end pulse (2 done, 1 poll err, 1+LOCK_TIMEOUT lock err)
    task automatic run_case(input string tag, input logic [17:0] n, input logic [17:0] m,
                            input logic [17:0] c, input logic [4:0] sel, input int nreads,
                            input int exp_kind, input logic [1:0] exp_code, input int extra,
                            output int lat);
        int acc, kind;
        do_req(n, m, c, sel, acc);
        wait_end(kind);
        lat = end_cyc - acc;
        chk({tag, "_kind"}, 64'(kind), 64'(exp_kind));
        chk({tag, "_lat"}, 64'(lat), 64'(xfer_cycles + extra));
        chk({tag, "_code"}, 64'(end_code), 64'(exp_code));
        chk({tag, "_busy_end"}, 64'(end_busy), 64'd0);
        build_exp(n, m, c, sel, nreads);
        check_log(tag);
    endtask

    initial begin
        int lat, acc, kind, d0;
        logic [17:0] rn, rm, rc;
        logic [4:0]  rs;

        reset_reset_n    = 1'b0;
        cfg_req          = 1'b0;
        cfg_n = 18'h0; cfg_m = 18'h0; cfg_c = 18'h0; cfg_c_sel = 5'h0;
        pll_locked       = 1'b1;
        mgmt_readdata    = 32'h0;
        mgmt_waitrequest = 1'b0;
        #1;
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_err",   64'(err), 64'd0);
        chk("rst_code",  64'(err_code), 64'd0);
        chk("rst_strb",  64'({mgmt_read, mgmt_write}), 64'd0);
        chk("rst_addr",  64'(mgmt_address), 64'd0);
        chk("rst_wdata", 64'(mgmt_writedata), 64'd0);
        repeat (3) @(posedge clk_clk);
        #3 reset_reset_n = 1'b1;
        repeat (4) @(posedge clk_clk);

        // Basic: zero stalls, immediate status, lock already high
        stall_fixed = 0; status_zeros = 0;
        run_case("basic", 18'h00202, 18'h01010, 18'h00404, 5'd2, 1, 1, 2'd0, 2, lat);
        chk("basic_lat8", 64'(lat), 64'd8);

        // Stall: three waitrequest cycles on every transfer
        stall_fixed = 3;
        run_case("stall", 18'h00202, 18'h01010, 18'h00404, 5'd2, 1, 1, 2'd0, 2, lat);
        chk("stall_lat26", 64'(lat), 64'd26);

        // Randomized requests, stalls and status poll counts
        for (int i = 0; i < 6; i++) begin
            stall_fixed  = -1;
            status_zeros = $urandom_range(0, POLL_LIMIT - 2);
            rn = 18'($urandom); rm = 18'($urandom); rc = 18'($urandom); rs = 5'($urandom);
            run_case("rand", rn, rm, rc, rs, status_zeros + 1, 1, 2'd0, 2, lat);
        end

        // Poll timeout: status never reports done
        stall_fixed = -1; status_zeros = 1000;
        d0 = done_cnt;
        run_case("poll_to", 18'h3ffff, 18'h00001, 18'h2a5a5, 5'd31, POLL_LIMIT, 2, 2'd1, 1, lat);
        chk("poll_to_nodone", 64'(done_cnt - d0), 64'd0);

        // Lock timeout, then a good request clears the code
        pll_locked = 1'b0;
        repeat (3) @(posedge clk_clk);
        status_zeros = 1;
        run_case("lock_to", 18'h10203, 18'h20304, 18'h30405, 5'd7, 2, 2, 2'd2, 1 + LOCK_TIMEOUT, lat);
        repeat (5) @(negedge clk_clk);
        chk("code_hold", 64'(err_code), 64'd2);
        pll_locked = 1'b1;
        repeat (3) @(posedge clk_clk);
        status_zeros = 0;
        run_case("after_lock_to", 18'h00303, 18'h00505, 18'h00707, 5'd1, 1, 1, 2'd0, 2, lat);

        // Request while busy is ignored
        stall_fixed = 0; status_zeros = 0;
        d0 = done_cnt;
        do_req(18'h01111, 18'h02222, 18'h03333, 5'd4, acc);
        @(posedge clk_clk); #1;
        @(posedge clk_clk); #1;
        chk("ign_in_wr_m", 64'(mgmt_address), 64'h04);
        cfg_n = 18'h3eeee; cfg_m = 18'h3dddd; cfg_c = 18'h3cccc; cfg_c_sel = 5'd9;
        cfg_req = 1'b1;
        @(posedge clk_clk); #1;
        cfg_req = 1'b0;
        wait_end(kind);
        chk("ign_kind", 64'(kind), 64'd1);
        build_exp(18'h01111, 18'h02222, 18'h03333, 5'd4, 1);
        check_log("ign");
        repeat (20) @(negedge clk_clk);
        chk("ign_one_done", 64'(done_cnt - d0), 64'd1);
        chk("ign_idle", 64'(busy), 64'd0);

        // Reset while a write is stalled, then a full clean run
        stall_fixed = 20;
        do_req(18'h00aaa, 18'h00bbb, 18'h00ccc, 5'd3, acc);
        @(posedge clk_clk); #2;
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_write", 64'(mgmt_write), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk_clk);
        #3 reset_reset_n = 1'b1;
        stall_fixed = 0; status_zeros = 0;
        run_case("post_rst", 18'h00123, 18'h00456, 18'h00789, 5'd5, 1, 1, 2'd0, 2, lat);

        repeat (3) @(posedge clk_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
